// File: rtl/sw_pkg.sv
// Stopwatch shared types: FSM state encoding, BCD digit limits, widths.
// Used by sw_ctrl_cnt, its interface and the sw_bcd_digit sub-module.
package sw_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } sw_state_e;

  localparam logic [3:0] DIG_MAX9 = 4'd9;
  localparam logic [3:0] DIG_MAX5 = 4'd5;

  localparam int TIME_W       = 24;
  localparam int TICK_DIV_DEF = 1600;

endpackage

// File: rtl/sw_ctrl_cnt_if.sv
// Button-level inputs and time/status outputs of the stopwatch stage.
// slave = stopwatch side, master = upstream sync / downstream display side.
interface sw_ctrl_cnt_if;
  import sw_pkg::*;

  logic              I_START_EN;
  logic              I_CLR_EN;
  logic              O_RUN;
  logic [TIME_W-1:0] O_TIME;
  logic              O_OVF;
  logic              O_LAP;

  modport slave (
    input  I_START_EN,
    input  I_CLR_EN,
    output O_RUN,
    output O_TIME,
    output O_OVF,
    output O_LAP
  );

  modport master (
    output I_START_EN,
    output I_CLR_EN,
    input  O_RUN,
    input  O_TIME,
    input  O_OVF,
    input  O_LAP
  );

endinterface

// File: rtl/sw_bcd_digit.sv
// One BCD digit counting 0..MAX; carry asserts when inc arrives at MAX.
// Chained six deep to form MM:SS.cc.
module sw_bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (inc) begin
      q_d = (q_q >= MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q_q <= 4'd0;
    else       q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = inc & (q_q == MAX);

endmodule

// File: rtl/sw_ctrl_cnt.sv
// Stopwatch control FSM, centisecond prescaler and MM:SS.cc BCD count.
// Optional lap hold (freeze O_TIME while counting) via SW_LAP_HOLD_EN.
module sw_ctrl_cnt
  import sw_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int PRE_W    = 11
) (
  input logic          I_CLK,
  input logic          I_RSTN,
  sw_ctrl_cnt_if.slave bus
);

  sw_state_e  state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic prev_start_q, prev_clr_q;
  logic run_q, run_d;
  logic ovf_q, ovf_d;
  logic start_pe, clr_pe, tick, dig_clr;
  logic c0, c1, c2, c3, c4, c5;
  logic [3:0] cs_l, cs_h, sec_l, sec_h, min_l, min_h;
  logic [TIME_W-1:0] live;

  assign start_pe = bus.I_START_EN & ~prev_start_q;
  assign clr_pe   = bus.I_CLR_EN & ~prev_clr_q;
  assign tick     = (state_q == S_RUN) &&
                    (pre_q == PRE_W'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    dig_clr = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start_pe) begin
          state_d = S_RUN;
          pre_d   = '0;
        end
      end
      (state_q == S_RUN): begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (start_pe) state_d = S_STOP;
      end
      (state_q == S_STOP): begin
        // clear outranks a simultaneous start here
        if (clr_pe) begin
          state_d = S_IDLE;
          pre_d   = '0;
          dig_clr = 1'b1;
        end else if (start_pe) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    run_d = (state_d == S_RUN);
    ovf_d = c5;
  end

  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      state_q      <= S_IDLE;
      pre_q        <= '0;
      prev_start_q <= 1'b1;
      prev_clr_q   <= 1'b1;
      run_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      prev_start_q <= bus.I_START_EN;
      prev_clr_q   <= bus.I_CLR_EN;
      run_q        <= run_d;
      ovf_q        <= ovf_d;
    end
  end

  sw_bcd_digit #(.MAX(DIG_MAX9)) u_cs_l (
    .clk(I_CLK), .rstn(I_RSTN), .clr(dig_clr),
    .inc(tick), .q(cs_l), .carry(c0)
  );
  sw_bcd_digit #(.MAX(DIG_MAX9)) u_cs_h (
    .clk(I_CLK), .rstn(I_RSTN), .clr(dig_clr),
    .inc(c0), .q(cs_h), .carry(c1)
  );
  sw_bcd_digit #(.MAX(DIG_MAX9)) u_sec_l (
    .clk(I_CLK), .rstn(I_RSTN), .clr(dig_clr),
    .inc(c1), .q(sec_l), .carry(c2)
  );
  sw_bcd_digit #(.MAX(DIG_MAX5)) u_sec_h (
    .clk(I_CLK), .rstn(I_RSTN), .clr(dig_clr),
    .inc(c2), .q(sec_h), .carry(c3)
  );
  sw_bcd_digit #(.MAX(DIG_MAX9)) u_min_l (
    .clk(I_CLK), .rstn(I_RSTN), .clr(dig_clr),
    .inc(c3), .q(min_l), .carry(c4)
  );
  sw_bcd_digit #(.MAX(DIG_MAX5)) u_min_h (
    .clk(I_CLK), .rstn(I_RSTN), .clr(dig_clr),
    .inc(c4), .q(min_h), .carry(c5)
  );

  assign live = {min_h, min_l, sec_h, sec_l, cs_h, cs_l};

  assign bus.O_RUN = run_q;
  assign bus.O_OVF = ovf_q;

`ifdef SW_LAP_HOLD_EN
  logic              lap_q, lap_d;
  logic [TIME_W-1:0] hold_q, hold_d;

  // leaving RUN drops the hold so STOP shows the live value
  always_comb begin
    lap_d  = lap_q;
    hold_d = hold_q;
    if (state_q == S_RUN) begin
      if (start_pe) begin
        lap_d = 1'b0;
      end else if (clr_pe) begin
        lap_d = ~lap_q;
        if (!lap_q) hold_d = live;
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      lap_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      lap_q  <= lap_d;
      hold_q <= hold_d;
    end
  end

  assign bus.O_TIME = lap_q ? hold_q : live;
  assign bus.O_LAP  = lap_q;
`else
  assign bus.O_TIME = live;
  assign bus.O_LAP  = 1'b0;
`endif

endmodule
